// File: rtl/led_blink_scheduler.sv
// Round-robin owner of a single status LED: each grant plays a fixed-length blink
// burst at the winner's rate, followed by an idle gap before the next arbitration.
module led_blink_scheduler #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned BLINKS   = 3,
  parameter int unsigned GAP_CYC  = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] rate,
  output logic               led,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_MAX = (TICK_DIV > GAP_CYC) ? TICK_DIV : GAP_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned TGL_W   = $clog2(2 * BLINKS + 1);
  localparam int unsigned PTR_W   = $clog2(N_REQ);

  localparam logic [TGL_W-1:0] TGL_PRE  = TGL_W'(2 * BLINKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLINK = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               led_q, led_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TGL_W-1:0]   tgl_q, tgl_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   half_q, half_d;   // latched half-period minus one

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;
  logic [1:0]         win_rate;
  logic [CNT_W-1:0]   win_half_m1;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = PTR_W'((32'(ptr_q) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_rate    = 2'(rate >> {win_idx, 1'b0});
    win_half_m1 = CNT_W'((TICK_DIV >> win_rate) - 1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    tgl_d   = tgl_q;
    ptr_d   = ptr_q;
    half_d  = half_q;

    case (state_q)
      IDLE: begin
        led_d   = 1'b1;
        grant_d = '0;
        if (enable && win_found) begin
          state_d = BLINK;
          grant_d = N_REQ'(1) << win_idx;
          ptr_d   = win_idx;
          half_d  = win_half_m1;
          cnt_d   = '0;
          tgl_d   = '0;
        end
      end
      BLINK: begin
        if (!enable) begin
          state_d = IDLE;
          led_d   = 1'b1;
          grant_d = '0;
          cnt_d   = '0;
          tgl_d   = '0;
        end else if (cnt_q == half_q) begin
          led_d = ~led_q;
          cnt_d = '0;
          tgl_d = tgl_q + TGL_W'(1);
          if (tgl_q == TGL_PRE) state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        led_d = 1'b1;
        if (!enable) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          tgl_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          grant_d = '0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = 1'b1;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      led_q   <= 1'b1;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      tgl_q   <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
      half_q  <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      tgl_q   <= tgl_d;
      ptr_q   <= ptr_d;
      half_q  <= half_d;
    end
  end

  assign led   = led_q;
  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler: time-since-grant reference model, directed
// scenarios followed by a randomized phase.
module tb_led_blink_scheduler;

  localparam int N_REQ    = 4;
  localparam int TICK_DIV = 8;
  localparam int BLINKS   = 2;
  localparam int GAP_CYC  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic [N_REQ-1:0]    req;
  logic [2*N_REQ-1:0]  rate;
  logic                led;
  logic [N_REQ-1:0]    grant;
  logic                busy;
  logic                done;

  int nchk  = 0;
  int npass = 0;

  // Model: owner (-1 = none), cycles since BLINK entry, half-period, rotation pointer.
  int m_owner = -1;
  int m_t     = 0;
  int m_h     = 1;
  int m_ptr   = N_REQ - 1;
  bit m_done  = 1'b0;

  led_blink_scheduler #(
    .N_REQ   (N_REQ),
    .TICK_DIV(TICK_DIV),
    .BLINKS  (BLINKS),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .req   (req),
    .rate  (rate),
    .led   (led),
    .grant (grant),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int burst_len();
    return 2 * BLINKS * m_h;
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    logic [1:0] r;
    m_done = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = N_REQ - 1;
    end else if (m_owner >= 0 && !enable) begin
      m_owner = -1;
    end else if (m_owner >= 0) begin
      m_t++;
      if (m_t == burst_len() + GAP_CYC) begin
        m_owner = -1;
        m_done  = 1'b1;
      end
    end else if (enable && (req != '0)) begin
      for (int k = 1; k <= N_REQ; k++) begin
        int i;
        i = (m_ptr + k) % N_REQ;
        if (m_owner < 0 && req[i]) m_owner = i;
      end
      m_ptr = m_owner;
      r     = rate[2*m_owner +: 2];
      m_h   = TICK_DIV >> r;
      m_t   = 0;
    end
  endtask

  task automatic tick();
    logic             e_led;
    logic [N_REQ-1:0] e_grant;
    @(posedge clk);
    model_step();
    #1;
    if (m_owner < 0) begin
      e_led   = 1'b1;
      e_grant = '0;
    end else begin
      e_led   = (m_t < burst_len()) ? (((m_t / m_h) % 2) == 0) : 1'b1;
      e_grant = N_REQ'(1) << m_owner;
    end
    chk("led",   32'(led),   32'(e_led));
    chk("grant", 32'(grant), 32'(e_grant));
    chk("busy",  32'(busy),  32'(m_owner >= 0));
    chk("done",  32'(done),  32'(m_done));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int ndone;
    int ngrant;
    logic [N_REQ-1:0] prev_grant;
    logic [N_REQ-1:0] first_grant;
    bit hit;

    // Reset with requests pending.
    rst = 1'b1; enable = 1'b1; req = 4'b1111; rate = '0;
    run(2);

    // Single requester at rate 0, past one full burst+gap and a re-grant.
    rst = 1'b0; req = 4'b0001;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("single_done_cnt", 32'(ndone), 32'd1);

    // All requesting: rotation across every requester with random rates.
    req = 4'b1111; rate = 8'($urandom);
    ndone = 0; ngrant = 0; prev_grant = grant;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done) ndone++;
      if (grant != '0 && grant != prev_grant) ngrant++;
      prev_grant = grant;
    end
    chk("rr_grants_seen", 32'(ngrant >= 5), 32'd1);
    chk("rr_done_vs_grant", 32'((ndone == ngrant) || (ndone == ngrant - 1)), 32'd1);

    // Fastest rate, then a mid-burst rate change that must be ignored.
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      req = 4'b0100; rate = 8'b0011_0000;
      tick();
      hit = (grant == 4'b0100);
    end
    chk("fast_grant_wait", 32'(hit), 32'd1);
    rate = '0;
    run(12);

    // Abort at BLINK cycle 10, then re-enable.
    req = 4'b1111; rate = '0;
    hit = (m_owner >= 0 && m_t == 10 && m_h == TICK_DIV);
    for (int i = 0; i < 150 && !hit; i++) begin
      tick();
      hit = (m_owner >= 0 && m_t == 10 && m_h == TICK_DIV);
    end
    chk("abort_wait", 32'(hit), 32'd1);
    enable = 1'b0;
    run(2);
    enable = 1'b1;
    run(20);

    // Reset during GAP cycle 2 restarts rotation at requester 0.
    hit = (m_owner >= 0 && m_t == burst_len() + 2);
    for (int i = 0; i < 150 && !hit; i++) begin
      tick();
      hit = (m_owner >= 0 && m_t == burst_len() + 2);
    end
    chk("gap_wait", 32'(hit), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    first_grant = grant;
    chk("post_rst_grant", 32'(first_grant), 32'b0001);
    run(10);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) rate = 8'($urandom);
      enable = ($urandom_range(0, 63) != 0);
      rst    = ($urandom_range(0, 255) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
